fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch stage with a prefetch buffer. It owns the program counter and drives the instruction memory's byte address. It captures each returned instruction word, together with its PC, into a small circular queue and hands entries to decode over a valid/ready handshake. A redirect from the execute stage (taken branch or jump) reloads the PC and discards every queued entry.

## Interface
- DEPTH, 4, queue entries; must be a power of two and at least 2.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  32  byte address of the next fetch; equals fetch_pc.
- imem_dout  input  32  instruction word at imem_addr; arrives combinationally in the same cycle.
- redirect_valid  input  1  high for one cycle to request a redirect.
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 00.
- out_valid  output  1  the queue head holds a valid instruction.
- out_inst  output  32  instruction at the queue head.
- out_pc  output  32  PC of the queue head.
- out_ready  input  1  decode accepts the head this cycle.
- occupancy  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.

## Operation
- State registers:
  - fetch_pc (32 bits).
  - head pointer and tail pointer (log2 DEPTH bits each, wrapping modulo DEPTH).
  - count.
  - entry arrays inst[DEPTH] and pc[DEPTH].
- Derived signals:
  - push = !redirect_valid && (count != DEPTH).
  - pop = !redirect_valid && out_valid && out_ready.
- On push:
  - inst[tail] <= imem_dout and pc[tail] <= fetch_pc.
  - tail increments.
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^32.
- On pop: head increments.
- count update:
  - count + 1 on push only.
  - count − 1 on pop only.
  - unchanged when both occur.
- When full (count == DEPTH), push is blocked even if a pop happens in the same cycle. fetch_pc holds, and imem_addr stays on the un-captured PC.
- Redirect has priority over everything else:
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - head, tail and count all go to 0.
  - No push and no pop occur that cycle. The head offered that cycle counts as not consumed, regardless of out_ready.
- Output assignments:
  - out_valid = (count != 0).
  - out_inst = inst[head] and out_pc = pc[head].
  - occupancy = count.
- When out_valid = 0, out_inst and out_pc are don't-care, but they must be stable (taken from storage, never from X).
- The block never consumes instruction data: no decode and no halt detection.

## Timing
- Reset (asynchronous, takes effect immediately):
  - fetch_pc = RESET_PC, so imem_addr = RESET_PC.
  - head = tail = count = 0, so out_valid = 0 and occupancy = 0.
  - All inst and pc entries clear to 0, so out_inst = 0 and out_pc = 0.
- Reset asserted mid-operation aborts everything at once. Nothing queued survives.
- Fetch latency is one edge. An instruction presented at imem_addr = P in cycle n appears at the head in cycle n+1 if the queue was empty.
- Steady state with out_ready held at 1 sustains one instruction per cycle, with the queue holding one entry.
- With out_ready held at 0, the queue fills after DEPTH edges and then stalls. occupancy = DEPTH and out_valid stays at 1.
- Redirect asserted in cycle n:
  - out_valid = 0 in cycle n+1.
  - imem_addr = target in cycle n+1.
  - The target instruction is at the head in cycle n+2.
- A redirect while the queue is empty or full behaves identically.
- Back-to-back redirects: the last one wins.
- Wrap-around: fetch_pc after 32'hFFFF_FFFC is 32'h0000_0000. Queue pointers wrap with no bubble.

## Test plan
- Reset, then 5 cycles with out_ready = 1 and memory word = address: out_pc sequence 0, 4, 8, 12 and out_inst equals out_pc; out_valid first high one cycle after reset deasserts.
- out_ready = 0 for 6 cycles: occupancy reaches 4 and holds; imem_addr sticks at 16; then out_ready = 1 drains PCs 0, 4, 8, 12, 16 in order with no gap or duplicate.
- Full queue, then out_ready = 1: on the pop cycle no push occurs (occupancy 4→3), and the next cycle refills to 3 with a pop.
- Redirect to 32'h0000_0103 while 3 entries are queued and out_ready = 1: next cycle occupancy = 0, out_valid = 0, imem_addr = 32'h100; the following cycle out_pc = 32'h100.
- RESET_PC = 32'hFFFF_FFF8, out_ready = 1: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert reset asynchronously mid-cycle while the queue is full: outputs go to 0 and imem_addr = RESET_PC before the next clock edge.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC and captures {inst, pc} pairs into a circular prefetch queue.
// Latency: a word fetched at cycle n is at the head in cycle n+1; a redirect target reaches the head two cycles after the redirect.
// Backpressure: out_ready low lets the queue fill to DEPTH, then fetch_pc holds until an entry pops.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_dout,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  output logic [31:0]                out_inst,
  output logic [31:0]                out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];

  logic full;
  logic push;
  logic pop;
  logic unused_redirect_lsbs;

  assign full  = (count == CW'(DEPTH));
  // A full queue blocks the push even when the head pops this cycle.
  assign push  = !redirect_valid && !full;
  assign pop   = !redirect_valid && out_valid && out_ready;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Storage is cleared on reset so the head outputs are never X, even when empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      inst_q[tail] <= imem_dout;
      pc_q[tail]   <= fetch_pc;
    end
  end

  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign out_inst  = inst_q[head];
  assign out_pc    = pc_q[head];
  assign occupancy = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory returns address ^ MEM_KEY so inst and pc are distinguishable.
// A second instance with RESET_PC = FFFF_FFF8 covers PC wrap-around.
module tb_fetch_queue;

  localparam logic [31:0] MEM_KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b0;

  logic [31:0] imem_addr, imem_dout, out_inst, out_pc;
  logic        out_valid;
  logic [2:0]  occupancy;

  logic [31:0] w_imem_addr, w_imem_dout, w_out_inst, w_out_pc;
  logic        w_out_valid;
  logic [2:0]  w_occupancy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_dout   = imem_addr ^ MEM_KEY;
  assign w_imem_dout = w_imem_addr ^ MEM_KEY;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset), .imem_addr(w_imem_addr), .imem_dout(w_imem_dout),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w_out_valid), .out_inst(w_out_inst), .out_pc(w_out_pc),
    .out_ready(out_ready), .occupancy(w_occupancy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;

    // Reset state
    step();
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_occ", {29'b0, occupancy}, 32'h0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_w_addr", w_imem_addr, 32'hFFFF_FFF8);

    // Streaming with out_ready = 1: one entry in flight, one instruction per cycle
    reset = 1'b0;
    out_ready = 1'b1;
    check("stream_valid0", {31'b0, out_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stream_valid", {31'b0, out_valid}, 32'h1);
      check("stream_pc", out_pc, 32'(4 * i));
      check("stream_inst", out_inst, 32'(4 * i) ^ MEM_KEY);
      check("stream_occ", {29'b0, occupancy}, 32'h1);
      exp_pc = 32'hFFFF_FFF8 + 32'(4 * i);
      check("wrap_pc", w_out_pc, exp_pc);
      check("wrap_inst", w_out_inst, exp_pc ^ MEM_KEY);
    end

    // Fill with out_ready = 0
    reset = 1'b1;
    out_ready = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      check("fill_occ", {29'b0, occupancy}, (i < 4) ? 32'(i) : 32'd4);
      check("fill_addr", imem_addr, (i < 4) ? 32'(4 * i) : 32'd16);
      check("fill_head", out_pc, 32'h0);
      check("fill_valid", {31'b0, out_valid}, 32'h1);
    end

    // Drain: first pop from full does not push, later cycles push and pop
    out_ready = 1'b1;
    step();
    check("drain_occ_first", {29'b0, occupancy}, 32'd3);
    check("drain_addr_first", imem_addr, 32'd16);
    check("drain_pc", out_pc, 32'd4);
    for (int i = 2; i <= 4; i++) begin
      step();
      check("drain_pc", out_pc, 32'(4 * i));
      check("drain_inst", out_inst, 32'(4 * i) ^ MEM_KEY);
      check("drain_occ", {29'b0, occupancy}, 32'd3);
    end

    // Redirect with 3 entries queued and out_ready = 1
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    check("redir_occ", {29'b0, occupancy}, 32'h0);
    check("redir_valid", {31'b0, out_valid}, 32'h0);
    check("redir_addr", imem_addr, 32'h100);
    step();
    check("redir_head_pc", out_pc, 32'h100);
    check("redir_head_inst", out_inst, 32'h100 ^ MEM_KEY);
    check("redir_head_valid", {31'b0, out_valid}, 32'h1);

    // Back-to-back redirects on a full queue: the last wins
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("full_occ", {29'b0, occupancy}, 32'd4);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect_pc = 32'h0000_0304;
    step();
    redirect_valid = 1'b0;
    check("b2b_addr", imem_addr, 32'h304);
    check("b2b_occ", {29'b0, occupancy}, 32'h0);
    step();
    check("b2b_head_pc", out_pc, 32'h304);

    // Asynchronous reset mid-cycle with a full queue
    for (int i = 0; i < 4; i++) step();
    check("pre_arst_occ", {29'b0, occupancy}, 32'd4);
    #2;
    reset = 1'b1;
    #1;
    check("arst_addr", imem_addr, 32'h0);
    check("arst_valid", {31'b0, out_valid}, 32'h0);
    check("arst_occ", {29'b0, occupancy}, 32'h0);
    check("arst_inst", out_inst, 32'h0);
    check("arst_pc", out_pc, 32'h0);
    check("arst_w_addr", w_imem_addr, 32'hFFFF_FFF8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
